sccb_target: RTL and testbench

SCCB responder (camera-side slave) that answers the OV7670-style 3-phase writes issued by the team's SCCB master. It also answers 2-phase-write / 2-phase-read sequences. It holds an internal 256x8 register file, acknowledges transfers addressed to DEV_ADDR, and drives SDA open-drain only, through an active-high pull-low enable. It is used as an on-FPGA camera model for loopback bring-up and as the scoreboard target in the master's testbench.

---
 rtl/sccb_target.sv | 222 ++++++++++++++++++++++
 tb/tb_sccb_target.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target.sv
// SCCB responder (camera-side target). It answers 3-phase writes and
// 2-phase write / 2-phase read sequences from an SCCB master. It holds a
// 256x8 register file and drives SDA open-drain through sda_drive_low.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus idle, waiting for START
// DEV       | shifting in the device address byte (+ direction bit)
// DACK      | acknowledging the device byte
// SUB       | shifting in the register sub-address
// SACK      | acknowledging the sub-address
// WR        | shifting in a data byte to commit at sub_addr
// WACK      | acknowledging a data byte, then back to WR (burst)
// RD        | shifting reg[sub_addr] out on SDA, MSB first
// RNA       | master's ACK/NA slot after a read byte (value ignored)
// WAIT_STOP | not addressed or transfer finished; wait for START/STOP
`timescale 1ns/1ps
module sccb_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_drive_low,
    output logic        wr_valid,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] wr_count,
    input  logic [7:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic        busy
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_DEV       = 4'd1;
    localparam logic [3:0] S_DACK      = 4'd2;
    localparam logic [3:0] S_SUB       = 4'd3;
    localparam logic [3:0] S_SACK      = 4'd4;
    localparam logic [3:0] S_WR        = 4'd5;
    localparam logic [3:0] S_WACK      = 4'd6;
    localparam logic [3:0] S_RD        = 4'd7;
    localparam logic [3:0] S_RNA       = 4'd8;
    localparam logic [3:0] S_WAIT_STOP = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_d;
    logic                   sda_d;

    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    logic [3:0]             state;
    logic [2:0]             bit_cnt;
    logic [6:0]             shreg;
    logic [7:0]             byte_in;
    logic                   byte_done;
    logic                   commit;
    logic [7:0]             sub_addr;
    logic                   rd_dir;
    logic [7:0]             rd_byte;
    logic                   rd_last;

    logic [7:0]             mem [256];

    // Bus synchronizers plus one history flop. Left unreset on purpose so a
    // reset never manufactures a fake SDA/SCL edge on the conditioned lines.
    always_ff @(posedge clk) begin
        scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
        sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        scl_d    <= scl_s;
        sda_d    <= sda_s;
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    assign byte_in   = {shreg, sda_s};
    assign byte_done = scl_rise & (bit_cnt == 3'd7);
    assign commit    = (state == S_WR) & byte_done & ~start_det & ~stop_det & ~reset;

    assign dbg_data  = mem[dbg_addr];
    assign busy      = (state != S_IDLE);

    // Register file write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[sub_addr] <= byte_in;
        end
    end

    // Protocol FSM: bit shifting, ACK generation, read data and write commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            bit_cnt       <= 3'd0;
            shreg         <= 7'd0;
            sub_addr      <= 8'd0;
            rd_dir        <= 1'b0;
            rd_byte       <= 8'd0;
            rd_last       <= 1'b0;
            sda_drive_low <= 1'b0;
            wr_valid      <= 1'b0;
            wr_addr       <= 8'd0;
            wr_data       <= 8'd0;
            wr_count      <= 16'd0;
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                state         <= S_DEV;
                bit_cnt       <= 3'd0;
                sda_drive_low <= 1'b0;
            end else if (stop_det) begin
                state         <= S_IDLE;
                bit_cnt       <= 3'd0;
                sda_drive_low <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                    end
                    S_DEV: begin
                        if (scl_rise) begin
                            shreg   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (byte_done) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state  <= S_DACK;
                                rd_dir <= byte_in[0];
                            end else begin
                                state <= S_WAIT_STOP;
                            end
                        end
                    end
                    S_SUB: begin
                        if (scl_rise) begin
                            shreg   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (byte_done) begin
                            sub_addr <= byte_in;
                            state    <= S_SACK;
                        end
                    end
                    S_WR: begin
                        if (scl_rise) begin
                            shreg   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (byte_done) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= sub_addr;
                            wr_data  <= byte_in;
                            wr_count <= wr_count + 16'd1;
                            sub_addr <= sub_addr + 8'd1;
                            state    <= S_WACK;
                        end
                    end
                    S_DACK, S_SACK, S_WACK: begin
                        // First fall pulls SDA low, second fall ends the slot.
                        if (scl_fall) begin
                            if (!sda_drive_low) begin
                                sda_drive_low <= 1'b1;
                            end else begin
                                sda_drive_low <= 1'b0;
                                bit_cnt       <= 3'd0;
                                if (state != S_DACK) begin
                                    state <= S_WR;
                                end else if (rd_dir) begin
                                    state         <= S_RD;
                                    rd_byte       <= mem[sub_addr];
                                    rd_last       <= 1'b0;
                                    sda_drive_low <= ~mem[sub_addr][7];
                                end else begin
                                    state <= S_SUB;
                                end
                            end
                        end
                    end
                    S_RD: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rd_last <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            if (rd_last) begin
                                sda_drive_low <= 1'b0;
                                state         <= S_RNA;
                            end else begin
                                sda_drive_low <= ~rd_byte[3'd7 - bit_cnt];
                            end
                        end
                    end
                    S_RNA: begin
                        if (scl_rise) begin
                            state <= S_WAIT_STOP;
                        end
                    end
                    S_WAIT_STOP: begin
                        sda_drive_low <= 1'b0;
                    end
                    default: begin
                        state         <= S_IDLE;
                        sda_drive_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: a bit-banged SCCB master drives the bus, and a
// register-file model (array + expected-write queue) predicts every commit,
// ACK level, read bit and debug read.
`timescale 1ns/1ps
module tb_sccb_target;

    localparam int Q = 40;  // quarter SCL period: 4 clk cycles

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_bus;
    logic        sda_drive_low;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] wr_count;
    logic [7:0]  dbg_addr = 8'd0;
    logic [7:0]  dbg_data;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [7:0]  mem_m [256];
    logic [7:0]  sub_m = 8'd0;
    logic [15:0] exp_cnt = 16'd0;
    bit          drove_low = 1'b0;
    logic [7:0]  stream_addr [72];

    assign sda_bus = m_sda & ~sda_drive_low;

    always #5 clk = ~clk;

    sccb_target #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .scl_in       (m_scl),
        .sda_in       (sda_bus),
        .sda_drive_low(sda_drive_low),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_count     (wr_count),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: every write strobe against the model queue, and the
    // write counter against the model count on every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                exp_cnt = 16'd0;
            end else begin
                if (sda_drive_low) drove_low = 1'b1;
                if (wr_valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wr_addr", 32'(wr_addr), 32'(mon_e.a));
                        check("wr_data", 32'(wr_data), 32'(mon_e.d));
                        exp_cnt = exp_cnt + 16'd1;
                    end
                end
                check("wr_count", 32'(wr_count), 32'(exp_cnt));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic bus_start();
        #Q m_sda = 1'b1;
        #Q m_scl = 1'b1;
        #Q m_sda = 1'b0;
        #Q m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        #Q m_sda = 1'b0;
        #Q m_scl = 1'b1;
        #Q m_sda = 1'b1;
        #Q;
    endtask

    task automatic send_bit(input logic b);
        #Q m_sda = b;
        #Q m_scl = 1'b1;
        #Q;
        #Q m_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        #Q m_sda = 1'b1;
        #Q m_scl = 1'b1;
        #Q ack = sda_bus;
        #Q m_scl = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] b, output logic na);
        for (int i = 7; i >= 0; i--) begin
            #Q m_sda = 1'b1;
            #Q m_scl = 1'b1;
            #Q b[i] = sda_bus;
            #Q m_scl = 1'b0;
        end
        #Q m_sda = 1'b1;
        #Q m_scl = 1'b1;
        #Q na = sda_bus;
        #Q m_scl = 1'b0;
    endtask

    task automatic idle_check(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_sda"}, 32'(sda_drive_low), 32'd0);
    endtask

    task automatic dbg_check(input string name, input logic [7:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #10;
        check(name, 32'(dbg_data), 32'(exp));
    endtask

    task automatic wr_begin(input logic [7:0] sub);
        logic ack;
        bus_start();
        send_byte(8'h42, ack);
        check("dev_ack", 32'(ack), 32'd0);
        send_byte(sub, ack);
        check("sub_ack", 32'(ack), 32'd0);
        sub_m = sub;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        logic ack;
        exp_q.push_back('{a: sub_m, d: d});
        mem_m[sub_m] = d;
        sub_m = sub_m + 8'd1;
        send_byte(d, ack);
        check("data_ack", 32'(ack), 32'd0);
    endtask

    task automatic rd_tx(output logic [7:0] b);
        logic ack;
        logic na;
        bus_start();
        send_byte(8'h43, ack);
        check("rd_dev_ack", 32'(ack), 32'd0);
        read_byte(b, na);
        check("rd_data", 32'(b), 32'(mem_m[sub_m]));
        check("rd_na_released", 32'(na), 32'd1);
        bus_stop();
        idle_check("rd_end");
    endtask

    initial begin
        logic       ack;
        logic [7:0] b;
        logic [7:0] d;
        logic [7:0] a;
        logic [7:0] dv;

        repeat (5) @(negedge clk);
        check("rst_sda", 32'(sda_drive_low), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #10;

        // 3-phase write 0x42,0x12,0x80
        wr_begin(8'h12);
        wr_byte(8'h80);
        bus_stop();
        idle_check("t1");
        dbg_check("t1_dbg", 8'h12, 8'h80);
        check("t1_count", 32'(wr_count), 32'd1);

        // Foreign device address: never acknowledged, never driven
        drove_low = 1'b0;
        bus_start();
        send_byte(8'h60, ack);
        check("t2_dev_nack", 32'(ack), 32'd1);
        send_byte(8'h12, ack);
        check("t2_b1_nack", 32'(ack), 32'd1);
        send_byte(8'h55, ack);
        check("t2_b2_nack", 32'(ack), 32'd1);
        bus_stop();
        check("t2_never_drove", 32'(drove_low), 32'd0);
        idle_check("t2");
        dbg_check("t2_dbg", 8'h12, 8'h80);

        // Preload 0x0A, set subaddress by 2-phase write, then 2-phase read
        wr_begin(8'h0A);
        wr_byte(8'hA5);
        bus_stop();
        wr_begin(8'h0A);
        bus_stop();
        rd_tx(b);
        check("t3_read_a5", 32'(b), 32'hA5);

        // Burst with sub-address wrap
        wr_begin(8'hFF);
        wr_byte(8'h11);
        wr_byte(8'h22);
        bus_stop();
        dbg_check("t4_dbg_ff", 8'hFF, 8'h11);
        dbg_check("t4_dbg_00", 8'h00, 8'h22);
        check("t4_count", 32'(wr_count), 32'd4);

        // STOP after 4 data bits: no write
        wr_begin(8'h12);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop();
        idle_check("t5a");
        dbg_check("t5a_dbg", 8'h12, 8'h80);
        check("t5a_count", 32'(wr_count), 32'd4);

        // Repeated START in the middle of the sub-address
        bus_start();
        send_byte(8'h42, ack);
        check("t5b_dev_ack", 32'(ack), 32'd0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        bus_start();
        check("t5b_busy", 32'(busy), 32'd1);
        check("t5b_sda", 32'(sda_drive_low), 32'd0);
        send_byte(8'h42, ack);
        check("t5b_dev2_ack", 32'(ack), 32'd0);
        send_byte(8'h30, ack);
        check("t5b_sub_ack", 32'(ack), 32'd0);
        sub_m = 8'h30;
        wr_byte(8'($urandom));
        bus_stop();
        check("t5b_count", 32'(wr_count), 32'd5);

        // Reset, then a 72-entry randomized init stream
        @(negedge clk);
        reset = 1'b1;
        #20;
        check("t6_rst_count", 32'(wr_count), 32'd0);
        reset = 1'b0;
        sub_m = 8'd0;
        #10;
        for (int i = 0; i < 72; i++) begin
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom);
            stream_addr[i] = a;
            wr_begin(a);
            wr_byte(d);
            bus_stop();
        end
        check("t6_count72", 32'(wr_count), 32'd72);
        for (int i = 0; i < 8; i++) begin
            a = stream_addr[$urandom_range(0, 71)];
            dbg_check("t6_dbg", a, mem_m[a]);
        end
        for (int i = 0; i < 3; i++) begin
            a = stream_addr[$urandom_range(0, 71)];
            wr_begin(a);
            bus_stop();
            rd_tx(b);
        end

        // Reset in the middle of the device-byte ACK
        dv = 8'h42;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(dv[i]);
        #Q m_sda = 1'b1;
        #Q m_scl = 1'b1;
        #20;
        check("t7_ack_before_reset", 32'(sda_drive_low), 32'd1);
        reset = 1'b1;
        #10;
        check("t7_rst_sda", 32'(sda_drive_low), 32'd0);
        check("t7_rst_count", 32'(wr_count), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #10;
        #Q m_scl = 1'b0;
        wr_begin(8'h5A);
        wr_byte(8'h3C);
        bus_stop();
        check("t7_count", 32'(wr_count), 32'd1);
        dbg_check("t7_dbg", 8'h5A, 8'h3C);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
